// File: rtl/main.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// main -- divide-by-2 clock generator with a 25% duty-cycle output.
//
// Two flops share clk but use opposite edges:
//   q toggles on every rising edge, and r samples q on every falling edge.
//   out = q & ~r is high only during the first high phase after q goes 0->1.
//   So out is high for half a clk period in every two clk periods.
//   out is built from the two flop outputs, so clk never reaches it directly.
//
// Reset is synchronous and active-high.
//   q clears on a rising edge and r clears on a falling edge.
//
// Optional feature: define MAIN_PULSE_CNT_EN to add the pulse_cnt output.
//   pulse_cnt is a wrapping counter of out pulses.
//   Without the macro, the port and the counter logic do not exist.
// ---------------------------------------------------------------------------
module main #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MAIN_PULSE_CNT_EN
    output logic [CNT_W-1:0] pulse_cnt,
`endif
    output logic             out
);

    // Reject counter widths outside the supported 2..32 range at elaboration
    if ((CNT_W < 32'sd2) || (CNT_W > 32'sd32)) begin : g_cnt_w_range
        $error("main: CNT_W must be within 2..32");
    end

    logic q_q;
    logic q_d;
    logic r_q;
    logic r_d;

    // Next state of the rising-edge flop: clear in reset, otherwise toggle
    always_comb begin
        q_d = 1'b0;
        if (reset) begin
            q_d = 1'b0;
        end else begin
            q_d = ~q_q;
        end
    end

    // Rising-edge divide-by-2 flop
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    // Next state of the falling-edge flop: clear in reset, otherwise follow q
    always_comb begin
        r_d = 1'b0;
        if (reset) begin
            r_d = 1'b0;
        end else begin
            r_d = q_q;
        end
    end

    // Falling-edge copy of q.
    // It ends each out pulse half a clk period after it starts.
    always_ff @(negedge clk) begin
        r_q <= r_d;
    end

    // out is high from the rising edge where q sets until r catches up.
    assign out = q_q & ~r_q;

`ifdef MAIN_PULSE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count each rising edge where q goes 0->1, which is where an out pulse starts.
    // The counter wraps naturally at 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (reset) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (!q_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pulse counter register, cleared with q on the rising edge
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign pulse_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_main.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_main -- directed, self-checking bench for main.
//
// clk has a 10 ns period, with rising edges at 5, 15, 25 ns and so on.
// The bench samples out in the middle of every half clk period.
// Half-phase m spans [5m, 5m+5) ns and is sampled at 5m+2.5 ns.
//
// The expected value for each sample comes from a timeline model of the
// reference waveform and is queued as a scoreboard entry.
// The bench then pops the entry at the sample point and compares it.
//
// A monitor records the times of out edges so the bench can check absolute
// pulse positions, periods and high times.
//
// Reset schedule:
//   - reset is high from 0 ns and released at 102.5 ns.
//   - reset is asserted again at 302.5 ns.
//   - the second assertion covers rising edges 305, 315 and 325 ns.
//   - reset is released again at 332.5 ns.
// ---------------------------------------------------------------------------
module tb_main;

    localparam int CNT_W  = 4;
    localparam int N_HALF = 290;

    logic clk;
    logic reset;
    logic out;
`ifdef MAIN_PULSE_CNT_EN
    logic [CNT_W-1:0] pulse_cnt;
`endif

    typedef struct {
        int   m;
        logic exp_out;
        int   exp_cnt;
    } exp_t;

    exp_t sb[$];
    time  rise_t[$];
    time  fall_t[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    main #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MAIN_PULSE_CNT_EN
        .pulse_cnt (pulse_cnt),
`endif
        .out       (out)
    );

    // 10 ns system clock, first rising edge at 5 ns
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge-time monitors, ignoring the initial settling near time zero
    always @(posedge out) if ($time > 50) rise_t.push_back($time);
    always @(negedge out) if ($time > 50) fall_t.push_back($time);

    // Reference waveform: out is high for the whole of half-phase m when a
    // pulse starts at its rising edge.
    //   - First run: pulses start at 105 ns (m=21), then every 20 ns until
    //     the second reset.
    //   - Second run: pulses restart at 335 ns (m=67).
    function automatic logic model_out(input int m);
        if (m >= 21 && m <= 60) return ((m - 21) % 4) == 0;
        if (m >= 67)            return ((m - 67) % 4) == 0;
        return 1'b0;
    endfunction

    // Pulses started so far in the current run, modulo 2^CNT_W.
    // The second reset takes effect at the rising edge at 305 ns (m=61).
    function automatic int model_cnt(input int m);
        int n;
        n = 0;
        if (m >= 21 && m <= 60) n = (m - 21) / 4 + 1;
        else if (m >= 67)       n = (m - 67) / 4 + 1;
        return n % (1 << CNT_W);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        exp_t e;
        exp_t e2;
        reset = 1'b1;
        #2.5;
        for (int m = 0; m < N_HALF; m++) begin
            if (m > 0) #5;
            // q and r are unknown before the first reset edges, so skip m=0
            if (m >= 1) begin
                e.m       = m;
                e.exp_out = model_out(m);
                e.exp_cnt = model_cnt(m);
                sb.push_back(e);
            end
            while (sb.size() > 0) begin
                e2 = sb.pop_front();
                chk($sformatf("out@%0dns", 5 * e2.m + 2), {63'd0, out}, {63'd0, e2.exp_out});
`ifdef MAIN_PULSE_CNT_EN
                chk($sformatf("cnt@%0dns", 5 * e2.m + 2), {60'd0, pulse_cnt}, 64'(e2.exp_cnt));
`endif
            end
`ifdef MAIN_PULSE_CNT_EN
            if (m == 62)  chk("cnt_after_reset", {60'd0, pulse_cnt}, 64'd0);
            if (m == 144) chk("cnt_wrap_20_pulses", {60'd0, pulse_cnt}, 64'd4);
`endif
            if (m == 20) reset = 1'b0;
            if (m == 60) reset = 1'b1;
            if (m == 66) reset = 1'b0;
        end

        // Edge timing.
        //   - First run: 10 pulses.
        //   - Second run: 56 pulses, from m=67 to m=287.
        chk("n_rise", 64'(rise_t.size()), 64'd66);
        chk("n_fall", 64'(fall_t.size()), 64'd66);
        if (rise_t.size() >= 61 && fall_t.size() >= 61) begin
            chk("rise0", rise_t[0], 64'd105);
            chk("fall0", fall_t[0], 64'd110);
            chk("rise1", rise_t[1], 64'd125);
            chk("fall1", fall_t[1], 64'd130);
            chk("restart_rise", rise_t[10], 64'd335);
            for (int k = 0; k < 50; k++) begin
                chk($sformatf("period%0d", k), rise_t[11 + k] - rise_t[10 + k], 64'd20);
                chk($sformatf("high%0d", k),   fall_t[10 + k] - rise_t[10 + k], 64'd5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
